// File: rtl/alu_logic_cmp_pipe.sv
// alu_logic_cmp_pipe: 2-stage valid/ready pipelined logic + compare slice.
// Bitwise XOR/XNOR/AND/OR of two WIDTH-bit operands with gr/eq/lt/zero flags.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand beat handshake
//   in_a, in_b           operands (WIDTH)
//   in_op                00 XOR, 01 XNOR, 10 AND, 11 OR
//   in_signed             1: two's-complement compare, 0: unsigned
//   out_valid/out_ready   result beat handshake
//   out_res               logic result (WIDTH)
//   out_gr/eq/lt          A > B, A == B, A < B
//   out_zero              out_res == 0
`timescale 1ns/1ps
module alu_logic_cmp_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_gr,
    output logic             out_eq,
    output logic             out_lt,
    output logic             out_zero
);

    localparam int MSB = WIDTH - 1;

    // Stage 1 registers
    logic           r_s1_v;
    logic [MSB:0]   r_s1_a;
    logic [MSB:0]   r_s1_b;
    logic [1:0]     r_s1_op;
    logic           r_s1_sgn;

    // Stage 2 registers
    logic           r_s2_v;
    logic [MSB:0]   r_s2_res;
    logic           r_s2_gr;
    logic           r_s2_eq;
    logic           r_s2_lt;
    logic           r_s2_zero;

    logic           w_s2_adv;
    logic           w_s1_adv;
    logic [MSB:0]   w_res;
    logic           w_eq;
    logic           w_gr_u;
    logic           w_hi_eq;
    logic           w_gr;
    logic           w_lt;
    logic           w_zero;

    assign w_s2_adv = !r_s2_v || out_ready;
    assign w_s1_adv = !r_s1_v || w_s2_adv;

    // Gated by rst_n so every output reads 0 while reset is held.
    assign in_ready = w_s1_adv && rst_n;

    always_comb begin
        w_res = '0;
        unique case (r_s1_op)
            2'b00: w_res = r_s1_a ^ r_s1_b;
            2'b01: w_res = ~(r_s1_a ^ r_s1_b);
            2'b10: w_res = r_s1_a & r_s1_b;
            2'b11: w_res = r_s1_a | r_s1_b;
            default: w_res = '0;
        endcase
    end

    // MSB-first unsigned greater-than: the first differing bit from the
    // top decides, so each bit is gated by equality of all bits above it.
    always_comb begin
        w_gr_u  = 1'b0;
        w_hi_eq = 1'b1;
        for (int i = MSB; i >= 0; i--) begin
            w_gr_u  = w_gr_u | (w_hi_eq & r_s1_a[i] & ~r_s1_b[i]);
            w_hi_eq = w_hi_eq & ~(r_s1_a[i] ^ r_s1_b[i]);
        end
    end

    assign w_eq = &(~(r_s1_a ^ r_s1_b));

    // Signed: differing sign bits decide on their own (non-negative wins).
    assign w_gr = (r_s1_sgn && (r_s1_a[MSB] != r_s1_b[MSB]))
                  ? ~r_s1_a[MSB] : w_gr_u;

    assign w_lt   = ~w_gr & ~w_eq;
    assign w_zero = ~|w_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v   <= 1'b0;
            r_s1_a   <= '0;
            r_s1_b   <= '0;
            r_s1_op  <= '0;
            r_s1_sgn <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_v <= in_valid;
            if (in_valid) begin
                r_s1_a   <= in_a;
                r_s1_b   <= in_b;
                r_s1_op  <= in_op;
                r_s1_sgn <= in_signed;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_v    <= 1'b0;
            r_s2_res  <= '0;
            r_s2_gr   <= 1'b0;
            r_s2_eq   <= 1'b0;
            r_s2_lt   <= 1'b0;
            r_s2_zero <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_s2_res  <= w_res;
                r_s2_gr   <= w_gr;
                r_s2_eq   <= w_eq;
                r_s2_lt   <= w_lt;
                r_s2_zero <= w_zero;
            end
        end
    end

    assign out_valid = r_s2_v;
    assign out_res   = r_s2_res;
    assign out_gr    = r_s2_gr;
    assign out_eq    = r_s2_eq;
    assign out_lt    = r_s2_lt;
    assign out_zero  = r_s2_zero;

endmodule

// File: tb/tb_alu_logic_cmp_pipe.sv
// tb_alu_logic_cmp_pipe: scoreboard bench for alu_logic_cmp_pipe.
// Drives an 8-bit and a 16-bit instance; compares every output beat.
`timescale 1ns/1ps
module tb_alu_logic_cmp_pipe;

    typedef struct {
        logic [19:0] exp;
        int          cyc;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // 8-bit instance
    logic       in_valid8, in_ready8, in_signed8;
    logic [7:0] in_a8, in_b8, out_res8;
    logic [1:0] in_op8;
    logic       out_valid8, out_ready8;
    logic       out_gr8, out_eq8, out_lt8, out_zero8;

    // 16-bit instance
    logic        in_valid16, in_ready16, in_signed16;
    logic [15:0] in_a16, in_b16, out_res16;
    logic [1:0]  in_op16;
    logic        out_valid16, out_ready16;
    logic        out_gr16, out_eq16, out_lt16, out_zero16;

    alu_logic_cmp_pipe #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .in_a      (in_a8),
        .in_b      (in_b8),
        .in_op     (in_op8),
        .in_signed (in_signed8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_res   (out_res8),
        .out_gr    (out_gr8),
        .out_eq    (out_eq8),
        .out_lt    (out_lt8),
        .out_zero  (out_zero8)
    );

    alu_logic_cmp_pipe #(.WIDTH(16)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .in_a      (in_a16),
        .in_b      (in_b16),
        .in_op     (in_op16),
        .in_signed (in_signed16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .out_res   (out_res16),
        .out_gr    (out_gr16),
        .out_eq    (out_eq16),
        .out_lt    (out_lt16),
        .out_zero  (out_zero16)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_in8 = 0, n_out8 = 0, n_in16 = 0, n_out16 = 0;
    logic lat_on = 1'b0;
    logic acc8, acc16;
    logic hold8 = 1'b0, hold16 = 1'b0;
    logic [20:0] held8, held16;
    logic [19:0] exp8_next, exp16_next;
    sb_t q8[$];
    sb_t q16[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] model(input int w, input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic [1:0] op,
                                          input logic s);
        logic [15:0] m, r, aa, bb;
        logic signed [16:0] sa, sb;
        m  = (w == 8) ? 16'h00FF : 16'hFFFF;
        aa = a & m;
        bb = b & m;
        case (op)
            2'd0:    r = aa ^ bb;
            2'd1:    r = ~(aa ^ bb);
            2'd2:    r = aa & bb;
            default: r = aa | bb;
        endcase
        r = r & m;
        if (!s) begin
            sa = {1'b0, aa};
            sb = {1'b0, bb};
        end else if (w == 8) begin
            sa = {{9{aa[7]}}, aa[7:0]};
            sb = {{9{bb[7]}}, bb[7:0]};
        end else begin
            sa = {aa[15], aa};
            sb = {bb[15], bb};
        end
        return {r, sa > sb, aa == bb, sa < sb, r == 16'h0};
    endfunction

    function automatic logic [19:0] e8(input logic [7:0] r, input logic g,
                                       input logic q, input logic l,
                                       input logic z);
        return {8'h00, r, g, q, l, z};
    endfunction

    // Sample just after the falling edge, account both handshakes for the
    // coming rising edge, then advance to the next falling edge.
    task automatic step();
        sb_t e;
        logic [19:0] cur8, cur16;
        #1;
        cyc++;
        cur8  = {8'h00, out_res8, out_gr8, out_eq8, out_lt8, out_zero8};
        cur16 = {out_res16, out_gr16, out_eq16, out_lt16, out_zero16};

        if (out_valid8 && out_ready8) begin
            check("sb8_pending", 32'(q8.size() != 0), 32'(1));
            if (q8.size() != 0) begin
                e = q8.pop_front();
                check("res8", 32'(cur8), 32'(e.exp));
                check("onehot8", 32'($countones({out_gr8, out_eq8, out_lt8})), 32'(1));
                if (lat_on) check("lat8", 32'(cyc - e.cyc), 32'(2));
            end
            n_out8++;
        end
        if (hold8) check("hold8", 32'({out_valid8, cur8}), 32'(held8));
        hold8 = out_valid8 && !out_ready8;
        held8 = {out_valid8, cur8};
        acc8 = in_valid8 && in_ready8;
        if (acc8) begin
            q8.push_back('{exp: exp8_next, cyc: cyc});
            n_in8++;
        end

        if (out_valid16 && out_ready16) begin
            check("sb16_pending", 32'(q16.size() != 0), 32'(1));
            if (q16.size() != 0) begin
                e = q16.pop_front();
                check("res16", 32'(cur16), 32'(e.exp));
                check("onehot16", 32'($countones({out_gr16, out_eq16, out_lt16})), 32'(1));
            end
            n_out16++;
        end
        if (hold16) check("hold16", 32'({out_valid16, cur16}), 32'(held16));
        hold16 = out_valid16 && !out_ready16;
        held16 = {out_valid16, cur16};
        acc16 = in_valid16 && in_ready16;
        if (acc16) begin
            q16.push_back('{exp: exp16_next, cyc: cyc});
            n_in16++;
        end
        @(negedge clk);
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op, input logic s,
                         input logic [19:0] ex);
        in_valid8  = 1'b1;
        in_a8      = a;
        in_b8      = b;
        in_op8     = op;
        in_signed8 = s;
        exp8_next  = ex;
        for (int k = 0; k < 20; k++) begin
            step();
            if (acc8) break;
        end
        check("accept8", 32'(acc8), 32'(1));
        in_valid8 = 1'b0;
    endtask

    task automatic rand8_beat();
        in_a8      = 8'($urandom);
        in_b8      = 8'($urandom);
        in_op8     = 2'($urandom);
        in_signed8 = 1'($urandom);
        exp8_next  = model(8, {8'h00, in_a8}, {8'h00, in_b8}, in_op8, in_signed8);
    endtask

    task automatic send8_rand();
        logic [7:0] a, b;
        logic [1:0] op;
        logic s;
        a  = 8'($urandom);
        b  = 8'($urandom);
        op = 2'($urandom);
        s  = 1'($urandom);
        send8(a, b, op, s, model(8, {8'h00, a}, {8'h00, b}, op, s));
    endtask

    logic [15:0] ba [6] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h1234, 16'hFFFF};
    logic [15:0] bb [6] = '{16'hFFFF, 16'h0000, 16'h7FFF, 16'h8000, 16'h1234, 16'hFFFF};

    initial begin
        int cnt;
        rst_n       = 1'b0;
        in_valid8   = 1'b0; in_a8 = '0; in_b8 = '0; in_op8 = '0; in_signed8 = 1'b0;
        in_valid16  = 1'b0; in_a16 = '0; in_b16 = '0; in_op16 = '0; in_signed16 = 1'b0;
        out_ready8  = 1'b1;
        out_ready16 = 1'b1;
        exp8_next   = '0;
        exp16_next  = '0;

        // Reset state
        #3;
        check("rst_valid8", 32'(out_valid8), 32'(0));
        check("rst_ready8", 32'(in_ready8), 32'(0));
        check("rst_out8", 32'({out_res8, out_gr8, out_eq8, out_lt8, out_zero8}), 32'(0));
        check("rst_valid16", 32'(out_valid16), 32'(0));
        check("rst_out16", 32'({out_res16, out_gr16, out_eq16, out_lt16, out_zero16}), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed beats, back-to-back, latency checked
        lat_on = 1'b1;
        send8(8'hA5, 8'h5A, 2'd0, 1'b0, e8(8'hFF, 1, 0, 0, 0));
        send8(8'h3C, 8'h3C, 2'd1, 1'b0, e8(8'hFF, 0, 1, 0, 0));
        send8(8'h3C, 8'h3C, 2'd0, 1'b0, e8(8'h00, 0, 1, 0, 1));
        send8(8'h80, 8'h01, 2'd0, 1'b0, e8(8'h81, 1, 0, 0, 0));
        send8(8'h80, 8'h01, 2'd0, 1'b1, e8(8'h81, 0, 0, 1, 0));
        send8(8'hFF, 8'hFE, 2'd0, 1'b1, e8(8'h01, 1, 0, 0, 0));
        send8(8'hF0, 8'h3C, 2'd2, 1'b0, e8(8'h30, 1, 0, 0, 0));
        send8(8'h00, 8'h00, 2'd3, 1'b1, e8(8'h00, 0, 1, 0, 1));
        send8(8'h7F, 8'h80, 2'd3, 1'b1, e8(8'hFF, 1, 0, 0, 0));
        send8(8'h7F, 8'h80, 2'd3, 1'b0, e8(8'hFF, 0, 0, 1, 0));
        for (int k = 0; k < 4; k++) step();

        // Stream of 6 beats; latency 2 on each implies consecutive results
        for (int k = 0; k < 6; k++) send8_rand();
        for (int k = 0; k < 4; k++) step();

        // Stall with continuous input offer
        lat_on     = 1'b0;
        out_ready8 = 1'b0;
        in_valid8  = 1'b1;
        rand8_beat();
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (acc8) begin
                cnt++;
                rand8_beat();
            end
        end
        check("stall_accepts", 32'(cnt), 32'(2));
        check("stall_in_ready", 32'(in_ready8), 32'(0));
        in_valid8  = 1'b0;
        out_ready8 = 1'b1;
        for (int k = 0; k < 6; k++) step();
        check("stall_drain_q", 32'(q8.size()), 32'(0));
        check("stall_in_out", 32'(n_out8), 32'(n_in8));

        // Reset with both stages full
        out_ready8 = 1'b0;
        send8_rand();
        send8_rand();
        #2;
        check("pre_rst_valid", 32'(out_valid8), 32'(1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid8), 32'(0));
        check("mid_rst_ready", 32'(in_ready8), 32'(0));
        check("mid_rst_res", 32'(out_res8), 32'(0));
        q8.delete();
        hold8 = 1'b0;
        @(negedge clk);
        rst_n      = 1'b1;
        out_ready8 = 1'b1;
        lat_on     = 1'b1;
        send8(8'h0F, 8'hF0, 2'd3, 1'b0, e8(8'hFF, 0, 0, 1, 0));
        for (int k = 0; k < 4; k++) step();
        check("post_rst_q", 32'(q8.size()), 32'(0));
        lat_on = 1'b0;

        // 16-bit: boundary pairs in all ops/modes, then random traffic
        for (int n = 0; n < 48 + 10000; n++) begin
            if (n < 48) begin
                in_a16      = ba[n / 8];
                in_b16      = bb[n / 8];
                in_op16     = 2'(n % 4);
                in_signed16 = 1'((n / 4) % 2);
            end else begin
                in_a16      = 16'($urandom);
                in_b16      = ($urandom_range(0, 15) == 0) ? in_a16 : 16'($urandom);
                in_op16     = 2'($urandom);
                in_signed16 = 1'($urandom);
            end
            exp16_next = model(16, in_a16, in_b16, in_op16, in_signed16);
            acc16 = 1'b0;
            for (int k = 0; k < 200; k++) begin
                in_valid16  = ($urandom_range(0, 3) != 0);
                out_ready16 = ($urandom_range(0, 3) != 0);
                step();
                if (acc16) break;
            end
            check("accept16", 32'(acc16), 32'(1));
        end
        in_valid16  = 1'b0;
        out_ready16 = 1'b1;
        for (int k = 0; k < 6; k++) step();
        check("drain16_q", 32'(q16.size()), 32'(0));
        check("in_out16", 32'(n_out16), 32'(n_in16));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
